// File: rtl/pe_ctrl_pkg.sv
// Shared types and default sizing for the PE row-convolution datapath
// (controller, scratchpads and MAC all size themselves from these).
package pe_ctrl_pkg;

  localparam int unsigned PE_FILT_W   = 3;
  localparam int unsigned PE_WIN_W    = 5;
  localparam int unsigned PE_ADDR_W   = 5;
  localparam int unsigned PE_MAC_LAT  = 2;
  localparam int unsigned PE_STRIDE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } pe_state_e;

  // A programmed stride of zero means unit stride
  function automatic logic [PE_STRIDE_W-1:0] eff_stride(input logic [PE_STRIDE_W-1:0] s);
    return (s == '0) ? PE_STRIDE_W'(1) : s;
  endfunction

endpackage

// File: rtl/pe_row_conv_ctrl_if.sv
// Operand-side (scratchpad/MAC) and psum-side handshake bundle of the PE row sequencer.
interface pe_row_conv_ctrl_if
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned FILT_W = PE_FILT_W,
  parameter int unsigned WIN_W  = PE_WIN_W,
  parameter int unsigned ADDR_W = PE_ADDR_W
) ();

  logic              in_valid;
  logic [FILT_W-1:0] filt_addr;
  logic [ADDR_W-1:0] ifmap_addr;
  logic              mac_en;
  logic              acc_clear;
  logic              psum_valid;
  logic              psum_ready;
  logic [WIN_W-1:0]  psum_win;

  modport master (
    input  in_valid, psum_ready,
    output filt_addr, ifmap_addr, mac_en, acc_clear, psum_valid, psum_win
  );

  modport slave (
    output in_valid, psum_ready,
    input  filt_addr, ifmap_addr, mac_en, acc_clear, psum_valid, psum_win
  );

endinterface

// File: rtl/pe_idx_counter.sv
// Modulo index counter: counts 0..max-1 while enabled, flags the wrap step.
module pe_idx_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;

  assign wrap  = en && (count_q == (max - W'(1)));
  assign count = count_q;

  // Next count: clear has priority, wrap returns to zero
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pe_row_conv_ctrl.sv
// Per-PE 1-D row convolution sequencer: walks filter taps per window, issues
// scratchpad addresses and MAC strobes, drains the MAC pipe and hands each
// psum downstream. Optional macro PE_ROW_CONV_STRIDE_EN adds a window stride port.
module pe_row_conv_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned FILT_W  = PE_FILT_W,
  parameter int unsigned WIN_W   = PE_WIN_W,
  parameter int unsigned ADDR_W  = PE_ADDR_W,
  parameter int unsigned MAC_LAT = PE_MAC_LAT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [FILT_W-1:0]      filt_len,
  input  logic [WIN_W-1:0]       num_win,
`ifdef PE_ROW_CONV_STRIDE_EN
  input  logic [PE_STRIDE_W-1:0] stride,
`endif
  pe_row_conv_ctrl_if.master     bus,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  pe_state_e          state_q, state_d;
  logic [FILT_W-1:0]  filt_len_q, filt_len_d;
  logic [WIN_W-1:0]   num_win_q, num_win_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [ADDR_W-1:0]  step_c;
  logic [FILT_W-1:0]  filt_idx;
  logic [WIN_W-1:0]   win_idx;
  logic               filt_wrap;
  logic               win_wrap;
  logic               start_c;
  logic               cfg_ok_c;
  logic               launch_c;
  logic               filt_en_c;
  logic               win_en_c;
  logic               win_clr_c;

  assign start_c   = (state_q == ST_IDLE) && start;
  assign cfg_ok_c  = (filt_len != '0) && (num_win != '0);
  assign launch_c  = start_c && cfg_ok_c;
  assign filt_en_c = (state_q == ST_RUN) && bus.in_valid;
  assign win_en_c  = (state_q == ST_OUT) && bus.psum_ready;
  assign win_clr_c = launch_c || (state_q == ST_DONE);

`ifdef PE_ROW_CONV_STRIDE_EN
  logic [PE_STRIDE_W-1:0] stride_q, stride_d;

  // Latch the window step at launch
  always_comb begin
    stride_d = stride_q;
    if (launch_c) begin
      stride_d = eff_stride(stride);
    end
  end

  // Stride register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stride_q <= '0;
    end else begin
      stride_q <= stride_d;
    end
  end

  assign step_c = ADDR_W'(stride_q);
`else
  assign step_c = ADDR_W'(1);
`endif

  // Filter tap index within the current window
  pe_idx_counter #(.W(FILT_W)) u_filt_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en    (filt_en_c),
    .clear (launch_c),
    .max   (filt_len_q),
    .count (filt_idx),
    .wrap  (filt_wrap)
  );

  // Window index within the row
  pe_idx_counter #(.W(WIN_W)) u_win_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en    (win_en_c),
    .clear (win_clr_c),
    .max   (num_win_q),
    .count (win_idx),
    .wrap  (win_wrap)
  );

  // Next-state, config latch, window base address and drain countdown
  always_comb begin
    state_d    = state_q;
    filt_len_d = filt_len_q;
    num_win_d  = num_win_q;
    base_d     = base_q;
    drain_d    = drain_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok_c) begin
            filt_len_d = filt_len;
            num_win_d  = num_win;
            base_d     = '0;
            state_d    = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (filt_wrap) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_W'(MAC_LAT - 1)) begin
          state_d = ST_OUT;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_OUT: begin
        if (bus.psum_ready) begin
          if (win_wrap) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            base_d  = base_q + step_c;
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        base_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, config and status registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      filt_len_q <= '0;
      num_win_q  <= '0;
      base_q     <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      filt_len_q <= filt_len_d;
      num_win_q  <= num_win_d;
      base_q     <= base_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Outputs decode registered state; only mac_en/acc_clear follow in_valid
  assign bus.mac_en     = filt_en_c;
  assign bus.acc_clear  = filt_en_c && (filt_idx == '0);
  assign bus.filt_addr  = (state_q == ST_RUN) ? filt_idx : '0;
  assign bus.ifmap_addr = (state_q == ST_RUN) ? (base_q + ADDR_W'(filt_idx)) : '0;
  assign bus.psum_valid = (state_q == ST_OUT);
  assign bus.psum_win   = (state_q == ST_OUT) ? win_idx : '0;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_pe_row_conv_ctrl.sv
// Self-checking bench for pe_row_conv_ctrl: a timeline model derives every
// cycle's expected outputs from the row config and the in_valid/psum_ready streams.
`timescale 1ns/1ps
module tb_pe_row_conv_ctrl;

  localparam int unsigned FILT_W  = 3;
  localparam int unsigned WIN_W   = 5;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned MAC_LAT = 2;
  localparam int MAXC = 4096;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [FILT_W-1:0] filt_len;
  logic [WIN_W-1:0]  num_win;
`ifdef PE_ROW_CONV_STRIDE_EN
  logic [2:0]        stride;
`endif
  logic              busy;
  logic              done;

  pe_row_conv_ctrl_if #(.FILT_W(FILT_W), .WIN_W(WIN_W), .ADDR_W(ADDR_W)) bus ();

  pe_row_conv_ctrl #(
    .FILT_W (FILT_W),
    .WIN_W  (WIN_W),
    .ADDR_W (ADDR_W),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .filt_len(filt_len),
    .num_win (num_win),
`ifdef PE_ROW_CONV_STRIDE_EN
    .stride  (stride),
`endif
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit iv  [MAXC];
  bit rdy [MAXC];
  bit e_mac [MAXC];
  bit e_clr [MAXC];
  bit e_pv  [MAXC];
  bit e_busy[MAXC];
  bit e_done[MAXC];
  bit e_achk[MAXC];
  int e_fa  [MAXC];
  int e_ia  [MAXC];
  int e_pw  [MAXC];

  // Fill the in_valid / psum_ready streams with the given percent-high odds
  task automatic fill_streams(input int piv, input int prdy);
    for (int i = 0; i < MAXC; i++) begin
      iv[i]  = ($urandom_range(0, 99) < piv);
      rdy[i] = ($urandom_range(0, 99) < prdy);
    end
  endtask

  // One full row: build the expected timeline, then drive and compare each cycle
  task automatic test_row(input string name, input int L, input int N, input int S);
    int t, t_end, se;
    bit ovf, fire;
    logic [4:0] obs, expv;
    for (int i = 0; i < MAXC; i++) begin
      e_mac[i] = 0; e_clr[i] = 0; e_pv[i] = 0; e_busy[i] = 0; e_done[i] = 0;
      e_achk[i] = 0; e_fa[i] = 0; e_ia[i] = 0; e_pw[i] = 0;
    end
`ifdef PE_ROW_CONV_STRIDE_EN
    se = (S == 0) ? 1 : S;
`else
    se = 1;
`endif
    t = 1;
    ovf = 0;
    for (int w = 0; w < N && !ovf; w++) begin
      for (int f = 0; f < L && !ovf; f++) begin
        fire = 0;
        while (!fire && !ovf) begin
          fire      = iv[t];
          e_busy[t] = 1;
          e_achk[t] = 1;
          e_fa[t]   = f;
          e_ia[t]   = (w * se + f) % (1 << ADDR_W);
          e_mac[t]  = fire;
          e_clr[t]  = fire && (f == 0);
          t++;
          if (t >= MAXC - 16) ovf = 1;
        end
      end
      for (int d = 0; d < MAC_LAT; d++) begin
        e_busy[t] = 1;
        t++;
      end
      fire = 0;
      while (!fire && !ovf) begin
        fire      = rdy[t];
        e_busy[t] = 1;
        e_pv[t]   = 1;
        e_pw[t]   = w;
        t++;
        if (t >= MAXC - 16) ovf = 1;
      end
    end
    if (ovf) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeline: got length >= %0d cycles, required < %0d", name, MAXC - 16, MAXC - 16);
      return;
    end
    e_busy[t] = 1;
    e_done[t] = 1;
    t_end = t;

    for (int cy = 0; cy <= t_end + 2; cy++) begin
      @(posedge clk);
      #1;
      start    = (cy == 0) ? 1'b1 : ((cy <= t_end) ? ($urandom_range(0, 7) == 0) : 1'b0);
      filt_len = (cy == 0) ? FILT_W'(L) : FILT_W'($urandom);
      num_win  = (cy == 0) ? WIN_W'(N) : WIN_W'($urandom);
`ifdef PE_ROW_CONV_STRIDE_EN
      stride   = (cy == 0) ? 3'(S) : 3'($urandom);
`endif
      bus.in_valid   = iv[cy];
      bus.psum_ready = rdy[cy];
      @(negedge clk);
      obs  = {busy, done, bus.mac_en, bus.acc_clear, bus.psum_valid};
      expv = {e_busy[cy], e_done[cy], e_mac[cy], e_clr[cy], e_pv[cy]};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s ctl cyc=%0d {busy,done,mac_en,acc_clear,psum_valid} got=%b exp=%b",
                 name, cy, obs, expv);
      end
      if (e_achk[cy]) begin
        n_checks++;
        if (bus.filt_addr !== FILT_W'(e_fa[cy]) || bus.ifmap_addr !== ADDR_W'(e_ia[cy])) begin
          n_fail++;
          $display("FAIL %s addr cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", name, cy,
                   bus.filt_addr, bus.ifmap_addr, e_fa[cy], e_ia[cy]);
        end
      end
      if (e_pv[cy]) begin
        n_checks++;
        if (bus.psum_win !== WIN_W'(e_pw[cy])) begin
          n_fail++;
          $display("FAIL %s psum_win cyc=%0d got=%0d exp=%0d", name, cy, bus.psum_win, e_pw[cy]);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    start = 1'b0; filt_len = '0; num_win = '0;
    bus.in_valid = 1'b0; bus.psum_ready = 1'b0;
`ifdef PE_ROW_CONV_STRIDE_EN
    stride = '0;
`endif
    for (int k = 0; k < 2; k++) begin
      #3;
      n_checks++;
      if ({busy, done, bus.mac_en, bus.acc_clear, bus.psum_valid,
           bus.filt_addr, bus.ifmap_addr, bus.psum_win} !== '0) begin
        n_fail++;
        $display("FAIL reset outputs: got busy=%b done=%b mac_en=%b psum_valid=%b, required all 0",
                 busy, done, bus.mac_en, bus.psum_valid);
      end
      repeat (2) @(posedge clk);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    fill_streams(100, 100);
    test_row("basic_L3_N2", 3, 2, 1);
  endtask

  task automatic test_stall();
    fill_streams(100, 100);
    for (int i = 3; i <= 6; i++) iv[i] = 0;
    test_row("stall4", 3, 2, 1);
  endtask

  task automatic test_backpressure();
    fill_streams(100, 100);
    for (int i = 6; i <= 10; i++) rdy[i] = 0;
    test_row("backpressure5", 3, 2, 1);
  endtask

  task automatic test_zero_cfg();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      filt_len = (k == 0) ? FILT_W'(0) : FILT_W'(3);
      num_win  = (k == 0) ? WIN_W'(5) : WIN_W'(0);
      bus.in_valid = 1'b1; bus.psum_ready = 1'b1;
      for (int cy = 0; cy < 3; cy++) begin
        if (cy > 0) begin
          @(posedge clk);
          #1;
          start = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, bus.mac_en} !== {1'b0, (cy == 1), 1'b0}) begin
          n_fail++;
          $display("FAIL zero_cfg%0d cyc=%0d {busy,done,mac_en} got=%b exp=%b",
                   k, cy, {busy, done, bus.mac_en}, {1'b0, (cy == 1), 1'b0});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    start = 1'b1; filt_len = 3; num_win = 3;
    bus.in_valid = 1'b1; bus.psum_ready = 1'b1;
`ifdef PE_ROW_CONV_STRIDE_EN
    stride = 3'd1;
`endif
    for (int cy = 1; cy <= 10; cy++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n_checks++;
    if ({busy, bus.mac_en, bus.psum_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_mid drain {busy,mac_en,psum_valid} got=%b exp=100",
               {busy, bus.mac_en, bus.psum_valid});
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bus.mac_en, bus.acc_clear, bus.psum_valid,
         bus.filt_addr, bus.ifmap_addr, bus.psum_win} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid async clear: got busy=%b mac_en=%b psum_valid=%b, required all 0",
               busy, bus.mac_en, bus.psum_valid);
    end
    @(negedge clk);
    rstn = 1'b1;
    fill_streams(100, 100);
    test_row("after_reset", 3, 3, 1);
  endtask

  task automatic test_stride();
    fill_streams(100, 100);
    test_row("stride2_N3", 3, 3, 2);
    fill_streams(90, 80);
    test_row("stride3_N16", 3, 16, 3);
    fill_streams(100, 100);
    test_row("stride0", 2, 3, 0);
  endtask

  task automatic test_boundaries();
    fill_streams(100, 100);
    test_row("max_L7_N31", 7, 31, 1);
    fill_streams(70, 70);
    test_row("single_tap", 1, 5, 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 15; r++) begin
      fill_streams($urandom_range(40, 100), $urandom_range(30, 100));
      test_row($sformatf("rand%0d", r), $urandom_range(1, 7), $urandom_range(1, 8),
               $urandom_range(0, 7));
    end
  endtask

  task automatic test_back_to_back();
    fill_streams(100, 100);
    test_row("b2b_a", 2, 2, 1);
    test_row("b2b_b", 4, 3, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_zero_cfg();
    test_reset_mid();
    test_stride();
    test_boundaries();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_row_conv_ctrl.md
Name: pe_row_conv_ctrl

Overview:
- Per-PE sequencer for a 1-D row convolution.
- Walks filter index and ifmap window index, and issues scratchpad read addresses plus MAC enable and accumulator-clear strobes.
- Waits out the MAC pipeline, then hands each finished partial sum downstream with a valid/ready handshake.
- Sits directly upstream of the PE filter/ifmap scratchpads and the MAC; it generates the index sequence those stages consume.

Parameters:
- FILT_W, 3, width of filter index and filt_len
- WIN_W, 5, width of window index and num_win
- ADDR_W, 5, width of ifmap scratchpad address
- MAC_LAT, 2, cycles from last mac_en until the accumulator holds the final psum (>=1)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a row; sampled only in IDLE
- filt_len  in  FILT_W  filter taps per window, latched at start
- num_win  in  WIN_W  windows (psums) per row, latched at start
- in_valid  in  1  scratchpad operands available this cycle; 0 stalls
- psum_ready  in  1  downstream accepts psum
- filt_addr  out  FILT_W  filter scratchpad read address
- ifmap_addr  out  ADDR_W  ifmap scratchpad read address
- mac_en  out  1  MAC consumes the current operands
- acc_clear  out  1  accumulator load instead of add; coincident with the first mac_en of a window
- psum_valid  out  1  finished psum available
- psum_win  out  WIN_W  window index of the presented psum
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at row completion

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, filt_idx=0, win_idx=0, drain counter=0, latched config=0.
  - All outputs 0.
  - Reset mid-row abandons the row; no done pulse.
- IDLE:
  - start=1 with filt_len!=0 and num_win!=0: latch both fields, clear indices, go RUN next cycle.
  - start=1 with either field 0: done pulses the next cycle, stay IDLE.
- RUN:
  - mac_en = in_valid.
  - filt_addr = filt_idx.
  - ifmap_addr = win_idx + filt_idx, zero-extended to ADDR_W, wraps modulo 2^ADDR_W.
  - acc_clear = in_valid & (filt_idx==0).
  - in_valid=1: if filt_idx == filt_len_q-1, filt_idx wraps to 0 and state goes DRAIN; otherwise filt_idx increments.
  - in_valid=0: all indices hold, mac_en=0 (stall of any length).
- DRAIN:
  - Counts MAC_LAT cycles with mac_en=0, then goes OUT.
- OUT:
  - psum_valid=1 and psum_win=win_idx, held stable until psum_ready=1.
  - On handshake: if win_idx == num_win_q-1 go DONE, otherwise win_idx increments and state goes RUN.
  - psum_ready outside OUT is ignored.
- DONE:
  - done=1 for exactly one cycle, win_idx cleared, go IDLE.
- General rules:
  - start outside IDLE is ignored.
  - filt_len/num_win changes after latch have no effect.
  - All outputs are registered or decoded from registered state only; no input-to-output combinational path except mac_en/acc_clear from in_valid.
- Latency, filt_len=L, MAC_LAT=M, no stalls, psum_ready tied 1:
  - First psum_valid appears 1+L+M cycles after start.
  - Each further window takes L+M+1 cycles.

Optional Feature:
- Macro PE_ROW_CONV_STRIDE_EN.
- Defined: adds input port stride [2:0], latched at start; stride 0 is treated as 1. ifmap_addr = win_idx*stride_q + filt_idx, truncated to ADDR_W.
- Undefined: port absent, stride fixed at 1.

Decomposition:
- Shared package pe_ctrl_pkg holds:
  - state enumeration IDLE/RUN/DRAIN/OUT/DONE (3-bit encoding);
  - default FILT_W/WIN_W/ADDR_W/MAC_LAT constants, shared with the scratchpad and MAC blocks.
- One natural sub-module: pe_idx_counter (en, clear, max input, count out, wrap flag when count==max-1 and en). Instantiated once for filt_idx and once for win_idx; the DRAIN counter is inline.

Test Plan:
- filt_len=3, num_win=2, MAC_LAT=2, in_valid=1, psum_ready=1, start at t0:
  - filt/ifmap addr pairs (0,0)(1,1)(2,2), then (0,1)(1,2)(2,3);
  - acc_clear on first tap of each window;
  - psum_valid at t6 (win 0) and t12 (win 1);
  - done at t13.
- Same config with in_valid low for 4 cycles after second tap: addresses hold, no mac_en during the gap, psum_valid delayed by exactly 4.
- psum_ready held 0 for 5 cycles in OUT: psum_valid and psum_win stay stable; win_idx advances only on handshake.
- start with filt_len=0, then num_win=0: done pulse one cycle later each time, busy never asserts, no mac_en.
- rstn asserted during DRAIN of window 1 of 3: all outputs 0 immediately; a fresh start runs a complete row from win 0.
- With PE_ROW_CONV_STRIDE_EN, stride=2, filt_len=3, num_win=3, ADDR_W=5:
  - ifmap_addr starts per window at 0, 2, 4;
  - with num_win=16, stride=3, window 15 addr truncates to (45+tap) mod 32.
